can_tx_prio_buffer: RTL and testbench

//  Multi-slot CAN transmit buffer bank; successor of the single high-priority buffer.

---
 rtl/can_tx_prio_buffer.sv | 181 ++++++++++++++++++
 tb/tb_can_tx_prio_buffer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_prio_buffer.sv
// Multi-slot CAN transmit buffer: host-loaded slots, lowest-identifier arbitration towards the
// bit-stream transmitter, slot locking while a frame is on the bus and retry on failure.
module can_tx_prio_buffer #(
  parameter int unsigned FRAME_W   = 128,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned ID_W      = 11,
  parameter int unsigned ID_LSB    = 117,
  localparam int unsigned SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 load_req,
  input  logic [SLOT_W-1:0]    load_slot,
  input  logic [FRAME_W-1:0]   load_data,
  output logic                 load_ack,
  output logic                 load_err,
  input  logic [NUM_SLOTS-1:0] abort_req,
  output logic [NUM_SLOTS-1:0] slot_full,
  output logic                 buf_full,
  output logic                 tx_valid,
  output logic [FRAME_W-1:0]   tx_data,
  output logic [SLOT_W-1:0]    tx_slot,
  input  logic                 tx_start,
  input  logic                 tx_done,
  input  logic                 tx_fail,
  output logic                 tx_busy
);

  localparam bit SlotPow2 = (NUM_SLOTS == (1 << SLOT_W));

  typedef enum logic [1:0] {StIdle, StSelect, StOffer, StActive} state_e;

  state_e               state_q, state_d;
  logic [NUM_SLOTS-1:0] slot_full_q, slot_full_d;
  logic [NUM_SLOTS-1:0] abort_pend_q, abort_pend_d;
  logic                 buf_full_q, buf_full_d;
  logic                 load_ack_q, load_ack_d;
  logic                 load_err_q, load_err_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 tx_busy_q, tx_busy_d;
  logic [FRAME_W-1:0]   tx_data_q, tx_data_d;
  logic [SLOT_W-1:0]    tx_slot_q, tx_slot_d;
  logic [FRAME_W-1:0]   mem_q [NUM_SLOTS];
  logic [FRAME_W-1:0]   mem_d [NUM_SLOTS];

  logic                 idx_ok, load_acc, preempt, bus_end, bus_clr;
  logic [NUM_SLOTS-1:0] locked, abort_eff, elig;
  logic                 win_vld;
  logic [SLOT_W-1:0]    win_idx;
  logic [ID_W-1:0]      win_id, off_id, load_id;

  assign idx_ok   = SlotPow2 || (32'(load_slot) < NUM_SLOTS);
  assign load_acc = load_req && idx_ok && !slot_full_q[load_slot];
  assign off_id   = tx_data_q[ID_LSB +: ID_W];
  assign load_id  = load_data[ID_LSB +: ID_W];

  // The slot on the bus cannot be cleared by an abort; the abort waits for the bus outcome.
  always_comb begin
    locked = '0;
    if (state_q == StActive) locked[tx_slot_q] = 1'b1;
    abort_eff = abort_req & slot_full_q & ~locked;
    elig      = slot_full_q & ~abort_eff;
  end

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_id  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (elig[i] && (!win_vld || mem_q[i][ID_LSB +: ID_W] < win_id)) begin
        win_vld = 1'b1;
        win_idx = SLOT_W'(i);
        win_id  = mem_q[i][ID_LSB +: ID_W];
      end
    end
  end

  assign bus_end = (state_q == StActive) && (tx_done || tx_fail);
  assign bus_clr = (state_q == StActive) &&
                   (tx_done || (tx_fail && (abort_pend_q[tx_slot_q] || abort_req[tx_slot_q])));
  assign preempt = (win_vld && win_id < off_id) || (load_acc && load_id < off_id);

  always_comb begin
    slot_full_d = slot_full_q & ~abort_eff;
    if (bus_clr) slot_full_d[tx_slot_q] = 1'b0;
    if (load_acc) slot_full_d[load_slot] = 1'b1;
    buf_full_d   = &slot_full_d;
    abort_pend_d = bus_end ? '0 : (abort_pend_q | (abort_req & locked));
    load_ack_d   = load_acc;
    load_err_d   = load_req && !load_acc;
    mem_d        = mem_q;
    if (load_acc) mem_d[load_slot] = load_data;
  end

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_busy_d  = tx_busy_q;
    tx_data_d  = tx_data_q;
    tx_slot_d  = tx_slot_q;
    unique case (state_q)
      StIdle: begin
        if (|slot_full_d) state_d = StSelect;
      end
      StSelect: begin
        if (win_vld) begin
          state_d    = StOffer;
          tx_valid_d = 1'b1;
          tx_data_d  = mem_q[win_idx];
          tx_slot_d  = win_idx;
        end else begin
          state_d = StIdle;
        end
      end
      StOffer: begin
        if (tx_start) begin
          state_d    = StActive;
          tx_valid_d = 1'b0;
          tx_busy_d  = 1'b1;
        end else if (abort_eff[tx_slot_q] || preempt) begin
          state_d    = StSelect;
          tx_valid_d = 1'b0;
        end
      end
      StActive: begin
        if (bus_end) begin
          state_d   = StSelect;
          tx_busy_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      tx_valid_q <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_slot_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_busy_q  <= tx_busy_d;
      tx_data_q  <= tx_data_d;
      tx_slot_q  <= tx_slot_d;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot_full_q  <= '0;
      buf_full_q   <= 1'b0;
      abort_pend_q <= '0;
      load_ack_q   <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      slot_full_q  <= slot_full_d;
      buf_full_q   <= buf_full_d;
      abort_pend_q <= abort_pend_d;
      load_ack_q   <= load_ack_d;
      load_err_q   <= load_err_d;
    end
  end

  // Frame storage carries no reset; a slot's contents only matter while its full flag is set.
  always_ff @(posedge sys_clk) begin
    mem_q <= mem_d;
  end

  assign load_ack  = load_ack_q;
  assign load_err  = load_err_q;
  assign slot_full = slot_full_q;
  assign buf_full  = buf_full_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign tx_slot   = tx_slot_q;
  assign tx_busy   = tx_busy_q;

endmodule

// File: tb/tb_can_tx_prio_buffer.sv
// Scoreboard bench for can_tx_prio_buffer: directed scenarios followed by random load/abort/
// transmit traffic checked against a set-of-slots reference model.
module tb_can_tx_prio_buffer;
  localparam int unsigned FRAME_W   = 128;
  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned ID_W      = 11;
  localparam int unsigned ID_LSB    = 117;
  localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS);

  logic                 sys_clk   = 1'b0;
  logic                 sys_rst_n = 1'b0;
  logic                 load_req  = 1'b0;
  logic [SLOT_W-1:0]    load_slot = '0;
  logic [FRAME_W-1:0]   load_data = '0;
  logic                 load_ack, load_err;
  logic [NUM_SLOTS-1:0] abort_req = '0;
  logic [NUM_SLOTS-1:0] slot_full;
  logic                 buf_full, tx_valid, tx_busy;
  logic [FRAME_W-1:0]   tx_data;
  logic [SLOT_W-1:0]    tx_slot;
  logic                 tx_start = 1'b0;
  logic                 tx_done  = 1'b0;
  logic                 tx_fail  = 1'b0;

  always #5 sys_clk = ~sys_clk;

  can_tx_prio_buffer #(
    .FRAME_W  (FRAME_W),
    .NUM_SLOTS(NUM_SLOTS),
    .ID_W     (ID_W),
    .ID_LSB   (ID_LSB)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .load_req (load_req),
    .load_slot(load_slot),
    .load_data(load_data),
    .load_ack (load_ack),
    .load_err (load_err),
    .abort_req(abort_req),
    .slot_full(slot_full),
    .buf_full (buf_full),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_slot  (tx_slot),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .tx_fail  (tx_fail),
    .tx_busy  (tx_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which slots hold a frame, their contents, what is on the bus.
  logic [FRAME_W-1:0]       m_data [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]     m_full = '0;
  int                       m_lock = -1;
  bit                       m_pend = 1'b0;
  logic [1:0]               exp_load_q [$];
  logic [SLOT_W+FRAME_W-1:0] exp_tx_q  [$];

  task automatic check(input string name, input logic [FRAME_W-1:0] act,
                       input logic [FRAME_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [ID_W-1:0] id_of(input logic [FRAME_W-1:0] f);
    return f[ID_LSB +: ID_W];
  endfunction

  function automatic logic [FRAME_W-1:0] mk(input logic [ID_W-1:0] id);
    logic [FRAME_W-1:0] f;
    f = {$urandom(), $urandom(), $urandom(), $urandom()};
    f[ID_LSB +: ID_W] = id;
    return f;
  endfunction

  function automatic int m_winner();
    int best;
    best = -1;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (m_full[i] && (best < 0 || id_of(m_data[i]) < id_of(m_data[best]))) best = i;
    return best;
  endfunction

  // Identifier not shared with any occupied slot, so the expected winner is unambiguous.
  function automatic logic [ID_W-1:0] pick_id();
    logic [ID_W-1:0] id;
    bit              clash;
    do begin
      id    = ID_W'($urandom_range(0, 63));
      clash = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++)
        if (m_full[i] && id_of(m_data[i]) == id) clash = 1'b1;
    end while (clash);
    return id;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT answers a load or hands over a frame.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (load_ack || load_err) begin
        if (exp_load_q.size() == 0)
          check("load_resp_unexpected", FRAME_W'({load_ack, load_err}), '0);
        else
          check("load_resp", FRAME_W'({load_ack, load_err}), FRAME_W'(exp_load_q.pop_front()));
      end
      if (tx_valid && tx_start) begin
        if (exp_tx_q.size() == 0)
          check("tx_take_unexpected", FRAME_W'(tx_valid), '0);
        else begin
          logic [SLOT_W+FRAME_W-1:0] e;
          e = exp_tx_q.pop_front();
          check("tx_take_slot", FRAME_W'(tx_slot), FRAME_W'(e[FRAME_W +: SLOT_W]));
          check("tx_take_data", tx_data, e[FRAME_W-1:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic m_apply_abort(input logic [NUM_SLOTS-1:0] abt);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (abt[i]) begin
        if (i == m_lock) m_pend = 1'b1;
        else m_full[i] = 1'b0;
      end
    end
  endtask

  task automatic do_load(input int slot, input logic [FRAME_W-1:0] data,
                         input logic [NUM_SLOTS-1:0] abt);
    bit ok;
    ok = (slot < NUM_SLOTS) && !m_full[slot];
    exp_load_q.push_back(ok ? 2'b10 : 2'b01);
    load_req  = 1'b1;
    load_slot = SLOT_W'(slot);
    load_data = data;
    abort_req = abt;
    step();
    load_req  = 1'b0;
    abort_req = '0;
    m_apply_abort(abt);
    if (ok) begin
      m_full[slot] = 1'b1;
      m_data[slot] = data;
    end
  endtask

  task automatic do_abort(input logic [NUM_SLOTS-1:0] abt);
    abort_req = abt;
    step();
    abort_req = '0;
    m_apply_abort(abt);
  endtask

  task automatic tx_take();
    int n;
    int w;
    repeat (3) step();
    n = 0;
    while (!tx_valid && n < 20) begin
      step();
      n++;
    end
    check("tx_valid_wait", FRAME_W'(tx_valid), FRAME_W'(1));
    if (tx_valid) begin
      w = m_winner();
      if (w >= 0) exp_tx_q.push_back({SLOT_W'(w), m_data[w]});
      tx_start = 1'b1;
      step();
      tx_start = 1'b0;
      m_lock   = w;
      m_pend   = 1'b0;
    end
  endtask

  task automatic tx_finish(input bit done, input bit fail);
    tx_done = done;
    tx_fail = fail;
    step();
    tx_done = 1'b0;
    tx_fail = 1'b0;
    if (m_lock >= 0) begin
      if (done || m_pend) m_full[m_lock] = 1'b0;
      m_lock = -1;
      m_pend = 1'b0;
    end
  endtask

  task automatic chk_state(input string name);
    check({name, "_slot_full"}, FRAME_W'(slot_full), FRAME_W'(m_full));
    check({name, "_buf_full"}, FRAME_W'(buf_full), FRAME_W'(&m_full));
  endtask

  task automatic chk_outputs_zero(input string name);
    check({name, "_ctrl"}, FRAME_W'({slot_full, buf_full, load_ack, load_err, tx_valid,
                                    tx_slot, tx_busy}), '0);
    check({name, "_tx_data"}, tx_data, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FRAME_W-1:0] f1;
    int                 r;
    int                 k;

    // Reset state
    repeat (3) step();
    chk_outputs_zero("reset");
    sys_rst_n = 1'b1;
    step();

    // First load: ack next cycle, offer two cycles after the load edge
    do_load(0, mk(11'h123), '0);
    check("t1_ack", FRAME_W'(load_ack), FRAME_W'(1));
    check("t1_slot_full", FRAME_W'(slot_full), FRAME_W'(4'b0001));
    check("t1_valid_early", FRAME_W'(tx_valid), '0);
    step();
    check("t1_valid", FRAME_W'(tx_valid), FRAME_W'(1));
    check("t1_tx_slot", FRAME_W'(tx_slot), '0);
    tx_take();
    tx_finish(1'b1, 1'b0);
    chk_state("t1_done");

    // Lower ID wins; done clears the slot and the next frame follows two cycles later
    f1 = mk(11'h200);
    do_load(1, f1, '0);
    do_load(2, mk(11'h050), '0);
    tx_take();
    check("t2_busy", FRAME_W'(tx_busy), FRAME_W'(1));
    check("t2_valid_drop", FRAME_W'(tx_valid), '0);
    tx_finish(1'b1, 1'b0);
    check("t2_slot_full", FRAME_W'(slot_full), FRAME_W'(4'b0010));
    check("t2_gap", FRAME_W'(tx_valid), '0);
    step();
    check("t2_valid", FRAME_W'(tx_valid), FRAME_W'(1));
    check("t2_tx_slot", FRAME_W'(tx_slot), FRAME_W'(1));

    // Rejected loads leave the stored frame intact
    do_load(1, mk(11'h7ff), '0);
    check("t3_err", FRAME_W'(load_err), FRAME_W'(1));
    check("t3_data_kept", tx_data, f1);
    do_load(5, mk(11'h001), '0);
    check("t3_err_idx", FRAME_W'(load_err), FRAME_W'(1));
    check("t3_data_kept2", tx_data, f1);

    // Preemption by a strictly lower ID during the offer
    do_load(3, mk(11'h010), '0);
    check("t4_valid_drop", FRAME_W'(tx_valid), '0);
    step();
    check("t4_valid", FRAME_W'(tx_valid), FRAME_W'(1));
    check("t4_tx_slot", FRAME_W'(tx_slot), FRAME_W'(3));

    // Retry after failure, then abort pending while on the bus
    tx_take();
    tx_finish(1'b0, 1'b1);
    step();
    check("t5_retry_valid", FRAME_W'(tx_valid), FRAME_W'(1));
    check("t5_retry_slot", FRAME_W'(tx_slot), FRAME_W'(3));
    tx_take();
    do_abort(4'b1000);
    chk_state("t5_abort_locked");
    tx_finish(1'b0, 1'b1);
    chk_state("t5_abort_applied");
    step();
    check("t5_next_slot", FRAME_W'(tx_slot), FRAME_W'(1));
    check("t5_next_valid", FRAME_W'(tx_valid), FRAME_W'(1));

    // Abort and load to the same full slot in one cycle
    do_load(1, mk(11'h001), 4'b0010);
    check("t5_abort_load_err", FRAME_W'(load_err), FRAME_W'(1));
    chk_state("t5_abort_load");
    repeat (3) step();
    check("t5_empty_idle", FRAME_W'(tx_valid), '0);

    // Equal IDs: buf_full, and index order on ties
    for (int i = 0; i < NUM_SLOTS; i++) do_load(i, mk(11'h0AA), '0);
    chk_state("t6_fill");
    for (int i = 0; i < NUM_SLOTS; i++) begin
      tx_take();
      check("t6_order", FRAME_W'(tx_slot), FRAME_W'(i));
      tx_finish(1'b1, 1'b0);
    end
    chk_state("t6_drained");

    // Reset while a frame is on the bus
    do_load(0, mk(11'h300), '0);
    do_load(2, mk(11'h100), '0);
    tx_take();
    check("t7_busy", FRAME_W'(tx_busy), FRAME_W'(1));
    sys_rst_n = 1'b0;
    #1;
    chk_outputs_zero("t7_reset");
    m_full = '0;
    m_lock = -1;
    m_pend = 1'b0;
    repeat (2) step();
    sys_rst_n = 1'b1;
    step();
    chk_state("t7_after_reset");

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        do_load($urandom_range(0, NUM_SLOTS - 1), mk(pick_id()),
                ($urandom_range(0, 9) == 0) ?
                  NUM_SLOTS'(1 << $urandom_range(0, NUM_SLOTS - 1)) : '0);
      end else if (r == 4) begin
        do_abort(NUM_SLOTS'(1 << $urandom_range(0, NUM_SLOTS - 1)));
      end else if (r <= 7) begin
        if (m_lock < 0 && m_full != '0) tx_take();
        else step();
      end else begin
        if (m_lock >= 0) begin
          k = $urandom_range(0, 2);
          tx_finish(k != 1, k != 0);
        end else begin
          step();
        end
      end
      chk_state("rnd");
    end

    repeat (3) step();
    check("load_q_drained", FRAME_W'(exp_load_q.size()), '0);
    check("tx_q_drained", FRAME_W'(exp_tx_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
